// File: rtl/router_coord_loader_pkg.sv
// router_coord_pkg: shared types and constants for the router coordinate loader.
//   coord_state_t : loader FSM states
//   SYNC_W        : width of the frame sync pattern
//   SYNC_PATTERN  : default sync pattern, MSB received first
package router_coord_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } coord_state_t;

  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010;

endpackage

// File: rtl/router_coord_loader_if.sv
// router_coord_loader_if: serial config stream plus committed coordinate outputs.
//   cfg_valid/cfg_bit/cfg_ready : bit stream handshake (transfer = valid & ready)
//   my_xpos/my_ypos             : committed coordinate
//   coord_load/cfg_err          : one-cycle commit / reject pulses
//   coord_valid                 : sticky, a coordinate has been committed
// master = stream source / coordinate consumer, slave = the loader.
interface router_coord_loader_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic           cfg_valid;
  logic           cfg_bit;
  logic           cfg_ready;
  logic [X_W-1:0] my_xpos;
  logic [Y_W-1:0] my_ypos;
  logic           coord_load;
  logic           coord_valid;
  logic           cfg_err;

  modport master (
    output cfg_valid, cfg_bit,
    input  cfg_ready, my_xpos, my_ypos, coord_load, coord_valid, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_bit,
    output cfg_ready, my_xpos, my_ypos, coord_load, coord_valid, cfg_err
  );
endinterface

// File: rtl/router_coord_loader_sync_det.sv
// router_coord_sync_det: sync pattern hunter.
//   clk, reset : clock, synchronous active-high reset
//   shift_en   : shift bit_in into the window this cycle
//   clr        : empty the window (takes priority over shift_en)
//   bit_in     : incoming serial bit
//   match      : window including bit_in equals SYNC (combinational)
module router_coord_sync_det
  import router_coord_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC = SYNC_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic clr,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_W-1:0] win_q, win_d, win_next;

  always_comb begin
    win_next = {win_q[SYNC_W-2:0], bit_in};
    match    = shift_en && (win_next == SYNC);
    win_d    = win_q;
    if (clr)
      win_d = '0;
    else if (shift_en)
      win_d = win_next;
  end

  always_ff @(posedge clk) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end

endmodule

// File: rtl/router_coord_loader.sv
// router_coord_loader: deserialises a sync-framed X/Y coordinate from a serial bit
// stream and commits it as registered parallel values for the slice position flops.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : router_coord_loader_if.slave (cfg stream in, coordinate/status out)
// Frame, MSB first: SYNC, X[X_W-1:0], Y[Y_W-1:0], optional P.
// Build option ROUTER_COORD_PARITY_EN: frame carries a trailing even-parity bit and
// bad frames raise cfg_err; without it every frame is accepted and cfg_err is 0.
//
// state   | meaning
// HUNT    | shifting bits through the sync window
// PAYLOAD | collecting X, Y (and P) into the payload shifter
// CHECK   | one cycle, stream stalled, frame committed or rejected
module router_coord_loader
  import router_coord_pkg::*;
#(
  parameter int                X_W  = 4,
  parameter int                Y_W  = 4,
  parameter logic [SYNC_W-1:0] SYNC = SYNC_PATTERN
) (
  input logic                  clk,
  input logic                  reset,
  router_coord_loader_if.slave bus
);

`ifdef ROUTER_COORD_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PLEN  = X_W + Y_W + PAR_W;
  localparam int CNT_W = $clog2(X_W + Y_W + 2);

  coord_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0]  sr_q, sr_d;
  logic [X_W-1:0]   xpos_q, xpos_d;
  logic [Y_W-1:0]   ypos_q, ypos_d;
  logic             load_q, load_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic ready, xfer, match, frame_ok;

  assign ready = ~reset & (state_q != CHECK);
  assign xfer  = bus.cfg_valid & ready;

`ifdef ROUTER_COORD_PARITY_EN
  // Even parity over X, Y and P.
  assign frame_ok = ~^sr_q;
`else
  assign frame_ok = 1'b1;
`endif

  // Window is emptied on a match so payload bits can never re-trigger sync.
  router_coord_sync_det #(.SYNC(SYNC)) u_sync_det (
    .clk      (clk),
    .reset    (reset),
    .shift_en (xfer && (state_q == HUNT)),
    .clr      (match),
    .bit_in   (bus.cfg_bit),
    .match    (match)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    valid_d = valid_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        if (match) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          sr_d  = {sr_q[PLEN-2:0], bus.cfg_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PLEN - 1))
            state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = HUNT;
        if (frame_ok) begin
          xpos_d  = sr_q[PLEN-1 -: X_W];
          ypos_d  = sr_q[PLEN-1-X_W -: Y_W];
          load_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sr_q    <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_ready   = ready;
  assign bus.my_xpos     = xpos_q;
  assign bus.my_ypos     = ypos_q;
  assign bus.coord_load  = load_q;
  assign bus.coord_valid = valid_q;
  assign bus.cfg_err     = err_q;

endmodule
